utopia_rx_phy_src: RTL

- PHY-side source for one Utopia Level 1 Rx port: buffers whole ATM cells and drives them toward the ATM-layer switch (squat) Rx input under its enable.
- One instance per Rx port in the bench/top, replacing behavioural PHY drivers.
- Cell-level handshake: clav reflects a complete buffered cell. Octet transfer is gated by the active-low enable.

---
 rtl/utopia_rx_phy_src.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/utopia_rx_phy_src.sv
// utopia_rx_phy_src: PHY-side source for one Utopia Level 1 Rx port.
// Whole ATM cells are buffered in NUM_CELLS slots. rx_clav is raised once a
// complete cell is waiting. Octets are driven one cycle after rx_en_n is
// sampled low.
// Optional build macro UTOPIA_HEC_GEN_EN: octet 4 (HEC) is regenerated as
// CRC-8 (x^8+x^2+x+1, init 0) over octets 0..3, XOR 0x55. The CRC is computed
// while the cell is written.
module utopia_rx_phy_src #(
    parameter int NUM_CELLS  = 4,
    parameter int CELL_BYTES = 53
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  wr_data,
    input  logic        wr_sop,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        wr_err,
    output logic [7:0]  rx_data,
    output logic        rx_soc,
    output logic        rx_clav,
    input  logic        rx_en_n,
    output logic [15:0] cells_sent
);

    localparam int PW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam int IW = $clog2(CELL_BYTES);
    localparam int AW = $clog2(NUM_CELLS * CELL_BYTES);
    localparam int CW = $clog2(NUM_CELLS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(CELL_BYTES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(NUM_CELLS);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Flat octet store: slot s, octet i lives at s*CELL_BYTES + i.
    logic [7:0] mem [NUM_CELLS * CELL_BYTES];

    function automatic logic [AW-1:0] cell_addr(input logic [PW-1:0] slot,
                                                input logic [IW-1:0] idx);
        return AW'(slot) * AW'(CELL_BYTES) + AW'(idx);
    endfunction

    // Write side state
    logic [IW-1:0] wi_q, wi_d;
    logic [PW-1:0] wp_q, wp_d;
    logic          wr_err_q, wr_err_d;
    logic          commit;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic          accept;

    // Read side state
    state_t        state_q, state_d;
    logic [IW-1:0] ri_q, ri_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_soc_q, rx_soc_d;
    logic [15:0]   cells_sent_q, cells_sent_d;
    logic          start, free;
    logic [7:0]    rd_octet;

    // Occupancy: slots holding committed cells not yet freed; avail: committed
    // cells whose transfer has not started.
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] avail_q, avail_d;
    logic          rx_clav_q, rx_clav_d;

    // A started cell already owns its slot, so only occupancy gates new writes.
    assign wr_ready   = ~rst & (occ_q < FULL_CNT);
    assign accept     = wr_valid & wr_ready;
    assign wr_err     = wr_err_q;
    assign rx_data    = rx_data_q;
    assign rx_soc     = rx_soc_q;
    assign rx_clav    = rx_clav_q;
    assign cells_sent = cells_sent_q;
    assign rd_octet   = mem[cell_addr(rp_q, ri_q)];

`ifdef UTOPIA_HEC_GEN_EN
    localparam logic [IW-1:0] HEC_IDX = IW'(4);
    logic [7:0] crc_q, crc_d;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // Running header CRC over octets 0..3 of the cell being written
    always_comb begin
        crc_d = crc_q;
        if (accept && wr_sop) begin
            crc_d = crc8_step(8'h00, wr_data);
        end else if (accept && wi_q != '0 && wi_q < HEC_IDX) begin
            crc_d = crc8_step(crc_q, wr_data);
        end
    end

    // Header CRC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= '0;
        else     crc_q <= crc_d;
    end
`endif

    // Write side: octet acceptance, sop framing errors and cell commit
    always_comb begin
        wi_d      = wi_q;
        wp_d      = wp_q;
        wr_err_d  = 1'b0;
        commit    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = cell_addr(wp_q, wi_q);
        mem_wdata = wr_data;
        if (accept) begin
            if (wr_sop) begin
                // A sop mid-cell discards the partial cell and restarts here.
                wr_err_d  = (wi_q != '0);
                mem_we    = 1'b1;
                mem_waddr = cell_addr(wp_q, '0);
                wi_d      = IW'(1);
            end else if (wi_q == '0) begin
                wr_err_d = 1'b1;
            end else begin
                mem_we = 1'b1;
`ifdef UTOPIA_HEC_GEN_EN
                if (wi_q == HEC_IDX) mem_wdata = crc_q ^ 8'h55;
`endif
                if (wi_q == LAST_IDX) begin
                    commit = 1'b1;
                    wi_d   = '0;
                    wp_d   = wp_q + 1'b1;
                end else begin
                    wi_d = wi_q + 1'b1;
                end
            end
        end
    end

    // Read FSM: start on enable with a cell available, stream, pause on rx_en_n
    always_comb begin
        state_d      = state_q;
        ri_d         = ri_q;
        rp_d         = rp_q;
        rx_data_d    = rx_data_q;
        rx_soc_d     = 1'b0;
        cells_sent_d = cells_sent_q;
        start        = 1'b0;
        free         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_en_n && rx_clav_q) begin
                    rx_data_d = rd_octet;
                    rx_soc_d  = 1'b1;
                    ri_d      = IW'(1);
                    start     = 1'b1;
                    state_d   = XFER;
                end
            end
            XFER: begin
                if (!rx_en_n) begin
                    rx_data_d = rd_octet;
                    if (ri_q == LAST_IDX) begin
                        ri_d         = '0;
                        rp_d         = rp_q + 1'b1;
                        cells_sent_d = cells_sent_q + 16'd1;
                        free         = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        ri_d = ri_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slot bookkeeping; a commit and a free in the same cycle cancel out
    always_comb begin
        unique case ({commit, free})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        unique case ({commit, start})
            2'b10:   avail_d = avail_q + 1'b1;
            2'b01:   avail_d = avail_q - 1'b1;
            default: avail_d = avail_q;
        endcase
        rx_clav_d = (avail_d != '0);
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wi_q         <= '0;
            wp_q         <= '0;
            wr_err_q     <= 1'b0;
            state_q      <= IDLE;
            ri_q         <= '0;
            rp_q         <= '0;
            rx_data_q    <= '0;
            rx_soc_q     <= 1'b0;
            cells_sent_q <= '0;
            occ_q        <= '0;
            avail_q      <= '0;
            rx_clav_q    <= 1'b0;
        end else begin
            wi_q         <= wi_d;
            wp_q         <= wp_d;
            wr_err_q     <= wr_err_d;
            state_q      <= state_d;
            ri_q         <= ri_d;
            rp_q         <= rp_d;
            rx_data_q    <= rx_data_d;
            rx_soc_q     <= rx_soc_d;
            cells_sent_q <= cells_sent_d;
            occ_q        <= occ_d;
            avail_q      <= avail_d;
            rx_clav_q    <= rx_clav_d;
        end
    end

    // Cell octet storage (data only, no reset)
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

endmodule
